// File: rtl/led_ctrl_pkg.sv
// Shared codes for the LED pattern controller: mode inputs, sequencer states
// and the mode-to-entry-state mapping used on restart.
package led_ctrl_pkg;

  localparam int STATE_W      = 3;
  localparam int PWM_BITS_DEF = 8;

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_SOLID   = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

  typedef enum logic [STATE_W-1:0] {
    S_OFF   = 3'd0,
    S_SOLID = 3'd1,
    S_UP    = 3'd2,
    S_HIGH  = 3'd3,
    S_DOWN  = 3'd4,
    S_LOW   = 3'd5
  } seq_state_e;

  function automatic seq_state_e entry_state(input logic [1:0] m);
    case (m)
      MODE_SOLID:   return S_SOLID;
      MODE_BLINK:   return S_HIGH;
      MODE_BREATHE: return S_UP;
      default:      return S_OFF;
    endcase
  endfunction

  function automatic logic is_busy(input seq_state_e s);
    return (s == S_UP) || (s == S_HIGH) || (s == S_DOWN) || (s == S_LOW);
  endfunction

endpackage

// File: rtl/led_pwm_gen.sv
// Free-running PWM: duty is latched only at the period boundary so a new
// target never shortens or stretches the period in progress.
module led_pwm_gen
  import led_ctrl_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [PWM_BITS-1:0] duty_tgt,
  output logic                LED
);

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS-1:0] duty_act;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pwm_cnt  <= '0;
      duty_act <= '0;
      LED      <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (pwm_cnt == '1) duty_act <= duty_tgt;
      LED <= (pwm_cnt < duty_act);
    end
  end

endmodule

// File: rtl/led_pattern_ctrl.sv
// LED pattern sequencer (off/solid/blink/breathe) driving a PWM generator;
// a mode change or EN rising restarts the pattern from its entry state.
module led_pattern_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int STEP_DIV   = 62500,
  parameter int HOLD_STEPS = 64
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [1:0]          MODE,
  input  logic [PWM_BITS-1:0] LEVEL,
  output logic                LED,
  output logic                USBPU,
  output logic                BUSY,
  output logic [STATE_W-1:0]  STATE
);

  localparam int PRE_W  = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  logic [PRE_W-1:0]    presc;
  logic                tick;
  seq_state_e          state, state_d;
  logic [PWM_BITS-1:0] duty_tgt, duty_d;
  logic [HOLD_W-1:0]   hold_cnt, hold_d;
  logic [1:0]          mode_q;
  logic                en_q;
  logic                restart, blink, hold_done;

  // Step prescaler free-runs; mode changes do not realign it.
  assign tick = (presc == PRE_LAST);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) presc <= '0;
    else if (tick) presc <= '0;
    else presc <= presc + 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mode_q <= MODE_OFF;
      en_q   <= 1'b0;
    end else begin
      mode_q <= MODE;
      en_q   <= EN;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_OFF;
      duty_tgt <= '0;
      hold_cnt <= '0;
    end else begin
      state    <= state_d;
      duty_tgt <= duty_d;
      hold_cnt <= hold_d;
    end
  end

  assign restart   = (MODE != mode_q) || !en_q;
  assign blink     = (mode_q == MODE_BLINK);
  assign hold_done = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_d = state;
    duty_d  = duty_tgt;
    hold_d  = hold_cnt;
    if (!EN) begin
      state_d = S_OFF;
      duty_d  = '0;
      hold_d  = '0;
    end else if (restart) begin
      state_d = entry_state(MODE);
      duty_d  = (MODE == MODE_SOLID || MODE == MODE_BLINK) ? LEVEL : '0;
      hold_d  = '0;
    end else begin
      case (state)
        S_OFF:   duty_d = '0;
        S_SOLID: duty_d = LEVEL;
        S_UP: begin
          // >= rather than == so a LEVEL lowered mid-ramp clamps next tick
          if (tick) begin
            if (duty_tgt >= LEVEL) begin
              duty_d  = LEVEL;
              state_d = S_HIGH;
            end else begin
              duty_d = duty_tgt + 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (blink) duty_d = LEVEL;
          if (tick) begin
            if (hold_done) begin
              hold_d = '0;
              if (blink) begin
                state_d = S_LOW;
                duty_d  = '0;
              end else begin
                state_d = S_DOWN;
              end
            end else begin
              hold_d = hold_cnt + 1'b1;
            end
          end
        end
        S_DOWN: begin
          if (tick) begin
            if (duty_tgt == '0) state_d = S_LOW;
            else duty_d = duty_tgt - 1'b1;
          end
        end
        S_LOW: begin
          duty_d = '0;
          if (tick) begin
            if (hold_done) begin
              hold_d = '0;
              if (blink) begin
                state_d = S_HIGH;
                duty_d  = LEVEL;
              end else begin
                state_d = S_UP;
              end
            end else begin
              hold_d = hold_cnt + 1'b1;
            end
          end
        end
        default: begin
          state_d = S_OFF;
          duty_d  = '0;
          hold_d  = '0;
        end
      endcase
    end
  end

  assign BUSY  = is_busy(state);
  assign STATE = state;
  assign USBPU = 1'b0;

  led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .CLK      (CLK),
    .RST      (RST),
    .duty_tgt (duty_tgt),
    .LED      (LED)
  );

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Scoreboard bench: scenarios queue cycle-stamped expectations, a negedge
// monitor compares them against STATE/BUSY/LED/duty and per-period LED counts.
module tb_led_pattern_ctrl;
  import led_ctrl_pkg::*;

  localparam int PB = 4, SD = 4, HS = 2;

  logic          CLK = 1'b0, RST = 1'b1, EN = 1'b0;
  logic [1:0]    MODE = 2'd0;
  logic [PB-1:0] LEVEL = '0;
  logic          LED, USBPU, BUSY;
  logic [2:0]    STATE;

  led_pattern_ctrl #(.PWM_BITS(PB), .STEP_DIV(SD), .HOLD_STEPS(HS)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .LEVEL(LEVEL),
    .LED(LED), .USBPU(USBPU), .BUSY(BUSY), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  typedef enum int {K_STATE, K_BUSY, K_LED, K_PERIOD, K_DUTY, K_USBPU} kind_e;
  typedef struct {
    int    cyc;
    kind_e kind;
    int    val;
    string name;
  } exp_t;
  typedef struct {
    int led;
    int busy;
    int st;
  } rst_exp_t;

  exp_t     sbq[$];
  rst_exp_t rstq[$];
  rst_exp_t re;
  int       n_tests = 0, n_fail = 0;
  int       cyc;
  int       led_acc = 0;

  // cycle index since reset release: edge k makes cyc == k
  always @(posedge CLK or posedge RST)
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int actual(input kind_e k);
    case (k)
      K_STATE:  return int'(STATE);
      K_BUSY:   return int'(BUSY);
      K_LED:    return int'(LED);
      K_PERIOD: return (cyc % 16 == 0) ? led_acc : -1;
      K_DUTY:   return int'(dut.duty_tgt);
      default:  return int'(USBPU);
    endcase
  endfunction

  // LED high-count per 16-clock period; window closes at cyc multiple of 16
  always @(negedge CLK) begin
    if (!RST && cyc >= 1) begin
      if (cyc % 16 == 1) led_acc = int'(LED);
      else               led_acc = led_acc + int'(LED);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].cyc < cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL %s: expectation for cyc %0d missed", sbq[i].name, sbq[i].cyc);
          sbq.delete(i);
        end else if (sbq[i].cyc == cyc) begin
          check(sbq[i].name, actual(sbq[i].kind), sbq[i].val);
          sbq.delete(i);
        end
      end
    end
  end

  always @(posedge RST) begin
    #1;
    if (rstq.size() > 0) begin
      re = rstq.pop_front();
      check("async_rst_led", int'(LED), re.led);
      check("async_rst_busy", int'(BUSY), re.busy);
      check("async_rst_state", int'(STATE), re.st);
    end
  end

  task automatic ex(input int c, input kind_e k, input int v, input string n);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic goto(input int c);
    for (int g = 0; g < 5000 && cyc < c; g++) @(negedge CLK);
  endtask

  task automatic drain();
    for (int g = 0; g < 300 && sbq.size() > 0; g++) @(negedge CLK);
    while (sbq.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: never observed (cyc %0d)", sbq[0].name, sbq[0].cyc);
      void'(sbq.pop_front());
    end
  endtask

  task automatic do_reset(input logic en, input logic [1:0] m, input logic [PB-1:0] lv);
    @(negedge CLK);
    RST = 1'b1; EN = en; MODE = m; LEVEL = lv;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // SOLID 5/16, LEVEL change mid-period only affects the following period
    do_reset(1'b1, MODE_SOLID, 4'd5);
    ex(2, K_STATE, 1, "solid_state");   ex(2, K_BUSY, 0, "solid_busy");
    ex(2, K_DUTY, 5, "solid_duty");     ex(16, K_PERIOD, 0, "solid_p0");
    ex(21, K_LED, 1, "solid_led_on");   ex(22, K_LED, 0, "solid_led_off");
    ex(30, K_USBPU, 0, "usbpu");        ex(32, K_PERIOD, 5, "solid_p1");
    ex(44, K_DUTY, 12, "solid_duty12"); ex(48, K_PERIOD, 5, "solid_p2_unchanged");
    ex(64, K_PERIOD, 12, "solid_p3_new");
    goto(40); LEVEL = 4'd12;
    drain();

    // OFF, then BLINK 8 phased so HIGH spans the period boundary; async reset mid-run
    do_reset(1'b1, MODE_OFF, 4'd8);
    ex(5, K_STATE, 0, "off_state");     ex(5, K_DUTY, 0, "off_duty");
    ex(13, K_STATE, 3, "blink_restart"); ex(13, K_DUTY, 8, "blink_duty_hi");
    ex(13, K_BUSY, 1, "blink_busy");    ex(19, K_STATE, 3, "blink_hold_hi");
    ex(20, K_STATE, 5, "blink_low");    ex(20, K_DUTY, 0, "blink_duty_lo");
    ex(20, K_BUSY, 1, "blink_busy_lo"); ex(24, K_LED, 1, "blink_led_on");
    ex(25, K_LED, 0, "blink_led_off");  ex(27, K_STATE, 5, "blink_hold_lo");
    ex(28, K_STATE, 3, "blink_high2");  ex(28, K_DUTY, 8, "blink_duty_hi2");
    ex(32, K_PERIOD, 8, "blink_p1");    ex(36, K_STATE, 5, "blink_low2");
    ex(44, K_STATE, 3, "blink_high3");  ex(48, K_PERIOD, 8, "blink_p2");
    ex(50, K_LED, 1, "pre_reset_led");  ex(50, K_USBPU, 0, "usbpu_blink");
    goto(12); MODE = MODE_BLINK;
    goto(50); #2;
    re.led = 0; re.busy = 0; re.st = 0;
    rstq.push_back(re);
    RST = 1'b1;
    #2;
    drain();

    // after reset with EN=0 the LED stays dark; EN rising restarts SOLID
    do_reset(1'b0, MODE_SOLID, 4'd9);
    ex(16, K_PERIOD, 0, "en0_p0");      ex(20, K_STATE, 0, "en0_state");
    ex(32, K_PERIOD, 0, "en0_p1");      ex(34, K_STATE, 1, "en_rise_solid");
    ex(48, K_PERIOD, 0, "en_rise_p2");  ex(64, K_PERIOD, 9, "en_rise_p3");
    goto(33); EN = 1'b1;
    drain();

    // BREATHE 3: ramp 0..3, hold, ramp down to 0, hold, ramp again
    do_reset(1'b1, MODE_BREATHE, 4'd3);
    ex(1, K_STATE, 2, "br3_up");        ex(1, K_BUSY, 1, "br3_busy");
    ex(1, K_DUTY, 0, "br3_d0");         ex(4, K_DUTY, 1, "br3_d1");
    ex(8, K_DUTY, 2, "br3_d2");         ex(12, K_DUTY, 3, "br3_d3");
    ex(12, K_STATE, 2, "br3_still_up"); ex(16, K_STATE, 3, "br3_high");
    ex(16, K_DUTY, 3, "br3_hold_d");    ex(20, K_STATE, 3, "br3_hold");
    ex(24, K_STATE, 4, "br3_down");     ex(24, K_DUTY, 3, "br3_down_d3");
    ex(28, K_DUTY, 2, "br3_dn2");       ex(32, K_DUTY, 1, "br3_dn1");
    ex(36, K_DUTY, 0, "br3_dn0");       ex(36, K_STATE, 4, "br3_down_at0");
    ex(40, K_STATE, 5, "br3_low");      ex(40, K_DUTY, 0, "br3_low_d");
    ex(44, K_STATE, 5, "br3_low_hold"); ex(48, K_STATE, 2, "br3_up2");
    ex(48, K_DUTY, 0, "br3_up2_d");     ex(52, K_DUTY, 1, "br3_up2_d1");
    ex(32, K_PERIOD, 3, "br3_p1");      ex(48, K_PERIOD, 2, "br3_p2");
    ex(64, K_PERIOD, 0, "br3_p3");
    drain();

    // BREATHE at max LEVEL: stops at 15, no wrap, 15/16 LED
    do_reset(1'b1, MODE_BREATHE, 4'd15);
    ex(36, K_DUTY, 9, "br15_d9");       ex(60, K_DUTY, 15, "br15_d15");
    ex(60, K_STATE, 2, "br15_up");      ex(64, K_STATE, 3, "br15_high");
    ex(64, K_DUTY, 15, "br15_no_wrap"); ex(72, K_STATE, 4, "br15_down");
    ex(76, K_DUTY, 14, "br15_dn14");    ex(80, K_PERIOD, 15, "br15_p4");
    drain();

    // LEVEL lowered mid-ramp clamps on the next tick
    do_reset(1'b1, MODE_BREATHE, 4'd15);
    ex(36, K_DUTY, 9, "clamp_pre_d");   ex(36, K_STATE, 2, "clamp_pre_st");
    ex(40, K_DUTY, 4, "clamp_duty");    ex(40, K_STATE, 3, "clamp_high");
    goto(37); LEVEL = 4'd4;
    drain();

    // LEVEL=0 BREATHE goes straight to HIGH on the first tick, LED dark
    do_reset(1'b1, MODE_BREATHE, 4'd0);
    ex(3, K_STATE, 2, "lvl0_up");       ex(4, K_STATE, 3, "lvl0_high");
    ex(4, K_DUTY, 0, "lvl0_duty");      ex(32, K_PERIOD, 0, "lvl0_p1");
    drain();

    // BREATHE->BLINK restart mid-ramp, EN=0 disable, EN rising restart
    do_reset(1'b1, MODE_BREATHE, 4'd6);
    ex(12, K_DUTY, 3, "rs_ramp_d");     ex(13, K_STATE, 2, "rs_ramp_st");
    ex(14, K_STATE, 3, "rs_blink");     ex(14, K_DUTY, 6, "rs_blink_d");
    ex(20, K_STATE, 5, "rs_blink_low"); ex(22, K_STATE, 0, "dis_state");
    ex(22, K_BUSY, 0, "dis_busy");      ex(22, K_DUTY, 0, "dis_duty");
    ex(32, K_PERIOD, 6, "dis_p1");      ex(48, K_PERIOD, 0, "dis_p2_off");
    ex(51, K_STATE, 3, "en_rise_blink"); ex(51, K_DUTY, 6, "en_rise_blink_d");
    goto(13); MODE = MODE_BLINK;
    goto(21); EN = 1'b0;
    goto(50); EN = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
